calc_accumulator: RTL

CALC_ACCUMULATOR -- requirements
Module: calc_accumulator

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_accumulator_if.sv | 30 +++
 rtl/calc_hist_stack.sv | 50 +++++
 rtl/calc_accumulator.sv | 135 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator accumulator: op encoding and widths.
package calc_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OPC_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OPC_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OPC_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OPC_SHL  = 3'b011;
   localparam logic [OP_W-1:0] OPC_SHR  = 3'b100;
   localparam logic [OP_W-1:0] OPC_AND  = 3'b101;
   localparam logic [OP_W-1:0] OPC_LOAD = 3'b110;
   localparam logic [OP_W-1:0] OPC_UNDO = 3'b111;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = OPC_ADD,
      OP_SUB  = OPC_SUB,
      OP_XOR  = OPC_XOR,
      OP_SHL  = OPC_SHL,
      OP_SHR  = OPC_SHR,
      OP_AND  = OPC_AND,
      OP_LOAD = OPC_LOAD,
      OP_UNDO = OPC_UNDO
   } op_e;

endpackage

// File: rtl/calc_accumulator_if.sv
// Command/status bundle between a controller and calc_accumulator.
interface calc_accumulator_if
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OPW   = 3,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic            en;
   logic [OP_W-1:0] op;
   logic [OPW-1:0]  operand;
   logic [WIDTH-1:0] acc;
   logic            zero;
   logic            carry;
   logic            overflow;
   logic [CW-1:0]   hist_count;
   logic            err;

   modport master (
      output en, op, operand,
      input  acc, zero, carry, overflow, hist_count, err
   );

   modport slave (
      input  en, op, operand,
      output acc, zero, carry, overflow, hist_count, err
   );
endinterface

// File: rtl/calc_hist_stack.sv
// Ring-buffer LIFO of previous accumulator values; a push on a full stack
// silently drops the oldest entry.
module calc_hist_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_top;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_top_inc;
   logic [PW-1:0]    w_top_dec;

   // r_top points at the next free slot; the newest entry sits just below it.
   assign w_top_inc = (r_top == PW'(DEPTH - 1)) ? '0 : r_top + PW'(1);
   assign w_top_dec = (r_top == '0) ? PW'(DEPTH - 1) : r_top - PW'(1);
   assign o_data    = r_mem[w_top_dec];
   assign o_count   = r_count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_top   <= '0;
         r_count <= '0;
      end else if (i_push) begin
         r_top <= w_top_inc;
         if (r_count != CW'(DEPTH)) begin
            r_count <= r_count + CW'(1);
         end
      end else if (i_pop && (r_count != '0)) begin
         r_top   <= w_top_dec;
         r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset_n && i_push) begin
         r_mem[r_top] <= i_data;
      end
   end
endmodule

// File: rtl/calc_accumulator.sv
// Edge-triggered accumulator ALU with flags, optional unsigned saturation
// and an undo history.
module calc_accumulator
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OPW   = 3,
   parameter int unsigned DEPTH = 4,
   parameter bit          SAT   = 1'b0
) (
   input  logic                clock,
   input  logic                reset_n,
   calc_accumulator_if.slave   bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             r_en_q;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic             r_overflow;
   logic             r_err;

   op_e              w_op;
   logic [WIDTH-1:0] w_opnd;
   logic             w_commit;
   logic             w_is_undo;
   logic             w_hist_empty;
   logic             w_undo_empty;
   logic             w_update;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_hist_data;
   logic [CW-1:0]    w_hist_count;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;

   assign w_op         = op_e'(bus.op);
   assign w_opnd       = WIDTH'(bus.operand);
   assign w_commit     = bus.en & ~r_en_q;
   assign w_is_undo    = (w_op == OP_UNDO);
   assign w_hist_empty = (w_hist_count == '0);
   assign w_undo_empty = w_commit & w_is_undo & w_hist_empty;
   assign w_update     = w_commit & ~w_undo_empty;
   assign w_push       = w_commit & ~w_is_undo;
   assign w_pop        = w_commit & w_is_undo & ~w_hist_empty;

   calc_hist_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_hist (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_acc),
      .o_data  (w_hist_data),
      .o_count (w_hist_count)
   );

   // Extra bit on the shifted vectors captures the last bit shifted out.
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, w_opnd};
      w_diff  = {1'b0, r_acc} - {1'b0, w_opnd};
      w_shl   = {1'b0, r_acc} << bus.operand;
      w_shr   = {r_acc, 1'b0} >> bus.operand;
      w_res   = r_acc;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      unique case (w_op)
         OP_ADD: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = ~r_acc[WIDTH-1] & w_sum[WIDTH-1];
            if (SAT && w_sum[WIDTH]) begin
               w_res = '1;
               w_ovf = 1'b0;
            end
         end
         OP_SUB: begin
            w_res   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];
            w_ovf   = r_acc[WIDTH-1] & ~w_diff[WIDTH-1];
            if (SAT && w_diff[WIDTH]) begin
               w_res = '0;
               w_ovf = 1'b0;
            end
         end
         OP_XOR:  w_res = r_acc ^ w_opnd;
         OP_AND:  w_res = r_acc & w_opnd;
         OP_LOAD: w_res = w_opnd;
         OP_SHL: begin
            w_res   = w_shl[WIDTH-1:0];
            w_carry = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res   = w_shr[WIDTH:1];
            w_carry = w_shr[0];
         end
         OP_UNDO: w_res = w_hist_data;
         default: w_res = r_acc;
      endcase
   end

   // en_q resets high so a level held through reset release is not a commit.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_en_q     <= 1'b1;
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_en_q <= bus.en;
         r_err  <= w_undo_empty;
         if (w_update) begin
            r_acc      <= w_res;
            r_carry    <= w_carry;
            r_overflow <= w_ovf;
         end
      end
   end

   assign bus.acc        = r_acc;
   assign bus.zero       = (r_acc == '0);
   assign bus.carry      = r_carry;
   assign bus.overflow   = r_overflow;
   assign bus.hist_count = w_hist_count;
   assign bus.err        = r_err;
endmodule
